// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 32-bit multiplier that borrows an external ALU for every
// add and shift, with early termination once the remaining multiplier is zero.
module alu_mult_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [3:0]  alu_operation,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_shamt,
    output logic [31:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_NOR = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SRL = 4'b0110
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        ADD,
        SHL,
        SHR,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= multiplicand;
                        mplier <= multiplier;
                        state  <= TEST;
                    end
                end
                TEST: begin
                    // The ALU ORs mplier with zero, so alu_zero means no bits remain.
                    if (alu_zero) begin
                        product <= acc;
                        state   <= DONE;
                    end else if (mplier[0]) begin
                        state <= ADD;
                    end else begin
                        state <= SHL;
                    end
                end
                ADD: begin
                    acc   <= alu_result;
                    state <= SHL;
                end
                SHL: begin
                    mcand <= alu_result;
                    state <= SHR;
                end
                SHR: begin
                    mplier <= alu_result;
                    state  <= TEST;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    alu_op_t op;

    always_comb begin
        op    = OP_AND;
        alu_a = '0;
        alu_b = '0;
        case (state)
            TEST: begin
                op    = OP_OR;
                alu_a = mplier;
            end
            ADD: begin
                op    = OP_ADD;
                alu_a = acc;
                alu_b = mcand;
            end
            SHL: begin
                op    = OP_SLL;
                alu_b = mcand;
            end
            SHR: begin
                op    = OP_SRL;
                alu_b = mplier;
            end
            default: ;
        endcase
    end

    assign alu_operation = op;
    assign alu_shamt     = 6'd1;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: a behavioural ALU closes the loop,
// stimulus queues hand-computed products/latencies, a monitor checks each done.
module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_shamt;
    logic [31:0] product;
    logic        busy;
    logic        done;

    alu_mult_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_operation(alu_operation),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_shamt    (alu_shamt),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural datapath ALU; shifts apply to operand B.
    always_comb begin
        case (alu_operation)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = ~(alu_a | alu_b);
            4'b0011: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a - alu_b;
            4'b0101: alu_result = alu_b << alu_shamt;
            4'b0110: alu_result = alu_b >> alu_shamt;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [31:0] prod;
        int unsigned lat;
        int unsigned k;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  oplog[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned shamt_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (alu_shamt !== 6'd1) shamt_bad++;
            if (busy) oplog.push_back(alu_operation);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_done", product, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check(product === e.prod, "product", product, e.prod);
                    check(cyc + 1 - e.k == e.lat, "latency", cyc + 1 - e.k, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input int unsigned lat, input bit track);
        exp_t e;
        @(negedge clk);
        #1;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        if (track) begin
            e.prod = p;
            e.lat  = lat;
            e.k    = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 400) begin
            check(1'b0, "timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(busy === 1'b0 && done === 1'b0, {tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check(alu_operation === 4'd0 && alu_a === 32'd0 && alu_b === 32'd0,
              {tag, "_alu_drive"}, alu_a | alu_b | 32'(alu_operation), 32'd0);
        check(alu_shamt === 6'd1, {tag, "_shamt"}, 32'(alu_shamt), 32'd1);
        check(product === 32'd0, {tag, "_product"}, product, 32'd0);
    endtask

    logic [3:0] exp_ops [12] = '{4'h1, 4'h3, 4'h5, 4'h6, 4'h1, 4'h5, 4'h6,
                                 4'h1, 4'h3, 4'h5, 4'h6, 4'h1};

    initial begin
        bit ops_ok;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        // Abort a long run with reset; no done may appear.
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0, 1'b0);
        repeat (50) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;

        issue(32'd7, 32'd6, 32'd42, 13, 1'b1);
        wait_idle();

        oplog.delete();
        issue(32'd3, 32'd5, 32'd15, 13, 1'b1);
        wait_idle();
        ops_ok = (oplog.size() == 13);
        if (ops_ok) begin
            for (int i = 0; i < 12; i++)
                if (oplog[i] !== exp_ops[i]) ops_ok = 1'b0;
            if (oplog[12] !== 4'h0) ops_ok = 1'b0;
        end
        check(ops_ok, "op_sequence", 32'(oplog.size()), 32'd13);

        issue(32'd12345, 32'd0, 32'd0, 2, 1'b1);
        wait_idle();
        issue(32'd0, 32'd12345, 32'd0, 50, 1'b1);
        wait_idle();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 130, 1'b1);
        wait_idle();
        issue(32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 14, 1'b1);
        wait_idle();

        // A start pulse mid-operation must be ignored.
        issue(32'd100, 32'd9, 32'd900, 16, 1'b1);
        repeat (4) @(negedge clk);
        issue(32'd2, 32'd3, 32'd6, 0, 1'b0);
        wait_idle();
        check(product === 32'd900, "ignored_start_hold", product, 32'd900);

        // Start held high: accepts spaced latency+1 apart.
        begin
            exp_t e;
            int unsigned n = 0;
            @(negedge clk);
            #1;
            start        = 1'b1;
            multiplicand = 32'd3;
            multiplier   = 32'd5;
            for (int i = 0; i < 3; i++) begin
                e.prod = 32'd15;
                e.lat  = 13;
                e.k    = cyc + 1 + 14 * i;
                sb.push_back(e);
            end
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                #2;
                n++;
            end
            start = 1'b0;
            if (n >= 200) begin
                check(1'b0, "held_start_timeout", 32'(sb.size()), 32'd0);
                sb.delete();
            end
            wait_idle();
        end

        check(shamt_bad == 0, "shamt_always_one", shamt_bad, 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
